// File: rtl/bank_cmd_arbiter.sv
// bank_cmd_arbiter: round-robin DRAM command arbiter with tRRD spacing and read/write turnaround.
// Define BANK_CMD_ARBITER_TFAW_EN to add the four-activate (tFAW) window.
module bank_cmd_arbiter #(
  parameter int unsigned NBANKS = 8,
  parameter int unsigned ABITS  = 14,
  parameter int unsigned BABITS = 3,
  parameter int unsigned TRRD   = 2,
  parameter int unsigned TRTW   = 3,
  parameter int unsigned TWTR   = 5
`ifdef BANK_CMD_ARBITER_TFAW_EN
  ,
  parameter int unsigned TFAW   = 16
`endif
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NBANKS-1:0]       cmd_valid,
  output logic [NBANKS-1:0]       cmd_ready,
  input  logic [NBANKS*ABITS-1:0] cmd_payload_a,
  input  logic [NBANKS-1:0]       cmd_payload_cas,
  input  logic [NBANKS-1:0]       cmd_payload_ras,
  input  logic [NBANKS-1:0]       cmd_payload_we,
  input  logic [NBANKS-1:0]       cmd_payload_is_cmd,
  input  logic [NBANKS-1:0]       cmd_payload_is_read,
  input  logic [NBANKS-1:0]       cmd_payload_is_write,
  output logic                    dfi_cs_n,
  output logic                    dfi_ras_n,
  output logic                    dfi_cas_n,
  output logic                    dfi_we_n,
  output logic [ABITS-1:0]        dfi_address,
  output logic [BABITS-1:0]       dfi_bank,
  output logic                    dfi_rddata_en,
  output logic                    dfi_wrdata_en
);
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {ST_READ, ST_RTW, ST_WRITE, ST_WTR} dir_e;

  dir_e              state_q, state_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic [CW-1:0]     trrd_q, trrd_d;
  logic [BABITS-1:0] last_q, last_d;
  logic              cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic              rden_q, rden_d, wren_q, wren_d;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [BABITS-1:0] bank_q, bank_d;

  logic [NBANKS-1:0] is_act, elig;
  logic              act_ok, faw_ok, gnt_vld, g_act;
  logic              rd_pend, wr_pend, rd_valid, wr_valid;
  logic [BABITS-1:0] gnt_idx, idx;

`ifdef BANK_CMD_ARBITER_TFAW_EN
  // History covers the previous TFAW-1 cycles; an ACT TFAW cycles ago no longer counts.
  localparam int unsigned FAW_D = TFAW - 1;
  localparam int unsigned FCW   = $clog2(TFAW) + 1;
  logic [FAW_D-1:0] faw_q, faw_d;
  logic [FCW-1:0]   faw_cnt;

  always_comb begin
    faw_cnt = '0;
    for (int i = 0; i < int'(FAW_D); i++) faw_cnt = faw_cnt + FCW'(faw_q[i]);
    faw_ok = (faw_cnt < FCW'(4));
    faw_d  = {faw_q[FAW_D-2:0], g_act};
  end
`else
  assign faw_ok = 1'b1;
`endif

  // Eligibility and round-robin grant starting after the last granted bank
  always_comb begin
    is_act  = cmd_payload_is_cmd & cmd_payload_ras & ~cmd_payload_cas & ~cmd_payload_we;
    act_ok  = (trrd_q == '0) & faw_ok;
    elig    = cmd_valid
            & ~(is_act & {NBANKS{~act_ok}})
            & ~(cmd_payload_is_read  & {NBANKS{state_q != ST_READ}})
            & ~(cmd_payload_is_write & {NBANKS{state_q != ST_WRITE}});
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    idx     = '0;
    for (int k = 1; k <= int'(NBANKS); k++) begin
      idx = last_q + BABITS'(k);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_vld   = gnt_vld & ~sys_rst;
    cmd_ready = '0;
    if (gnt_vld) cmd_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    trrd_d   = trrd_q;
    last_d   = last_q;
    g_act    = gnt_vld & is_act[gnt_idx];
    rd_pend  = |(elig & cmd_payload_is_read);
    wr_pend  = |(elig & cmd_payload_is_write);
    rd_valid = |(cmd_valid & cmd_payload_is_read);
    wr_valid = |(cmd_valid & cmd_payload_is_write);

    if (gnt_vld) last_d = gnt_idx;
    if (g_act) trrd_d = CW'(TRRD - 1);
    else if (trrd_q != '0) trrd_d = trrd_q - CW'(1);

    // Direction changes run to completion once started
    case (state_q)
      ST_READ: if (!rd_pend && wr_valid) begin
        state_d = ST_RTW;
        tcnt_d  = CW'(TRTW - 1);
      end
      ST_RTW: if (tcnt_q == '0) state_d = ST_WRITE;
              else tcnt_d = tcnt_q - CW'(1);
      ST_WRITE: if (!wr_pend && rd_valid) begin
        state_d = ST_WTR;
        tcnt_d  = CW'(TWTR - 1);
      end
      ST_WTR: if (tcnt_q == '0) state_d = ST_READ;
              else tcnt_d = tcnt_q - CW'(1);
      default: state_d = ST_READ;
    endcase

    cs_n_d  = 1'b1;
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    addr_d  = '0;
    bank_d  = '0;
    rden_d  = 1'b0;
    wren_d  = 1'b0;
    if (gnt_vld) begin
      cs_n_d  = 1'b0;
      ras_n_d = ~cmd_payload_ras[gnt_idx];
      cas_n_d = ~cmd_payload_cas[gnt_idx];
      we_n_d  = ~cmd_payload_we[gnt_idx];
      addr_d  = cmd_payload_a[gnt_idx*ABITS +: ABITS];
      bank_d  = gnt_idx;
      rden_d  = cmd_payload_is_read[gnt_idx];
      wren_d  = cmd_payload_is_write[gnt_idx];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_READ;
      tcnt_q  <= '0;
      trrd_q  <= '0;
      last_q  <= BABITS'(NBANKS - 1);
      cs_n_q  <= 1'b1;
      ras_n_q <= 1'b1;
      cas_n_q <= 1'b1;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      bank_q  <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
`ifdef BANK_CMD_ARBITER_TFAW_EN
      faw_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      trrd_q  <= trrd_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
`ifdef BANK_CMD_ARBITER_TFAW_EN
      faw_q   <= faw_d;
`endif
    end
  end

  assign dfi_cs_n      = cs_n_q;
  assign dfi_ras_n     = ras_n_q;
  assign dfi_cas_n     = cas_n_q;
  assign dfi_we_n      = we_n_q;
  assign dfi_address   = addr_q;
  assign dfi_bank      = bank_q;
  assign dfi_rddata_en = rden_q;
  assign dfi_wrdata_en = wren_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Testbench for bank_cmd_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model built from the arbitration and timing rules.
module tb_bank_cmd_arbiter;
  localparam int NB   = 8;
  localparam int AB   = 14;
  localparam int BAB  = 3;
  localparam int TRRD = 2;
  localparam int TRTW = 3;
  localparam int TWTR = 5;
`ifdef BANK_CMD_ARBITER_TFAW_EN
  localparam int TFAW = 16;
`endif
  localparam int T_ACT = 0, T_PRE = 1, T_RD = 2, T_WR = 3;
  localparam logic [22:0] DFI_NOP = {4'b1111, 2'b00, 3'b000, 14'h0};

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [NB-1:0]     cmd_valid, cmd_ready;
  logic [NB*AB-1:0]  cmd_payload_a;
  logic [NB-1:0]     cmd_payload_cas, cmd_payload_ras, cmd_payload_we;
  logic [NB-1:0]     cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write;
  logic              dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_rddata_en, dfi_wrdata_en;
  logic [AB-1:0]     dfi_address;
  logic [BAB-1:0]    dfi_bank;
  logic [22:0]       dfi_vec;

  assign dfi_vec = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_rddata_en, dfi_wrdata_en,
                    dfi_bank, dfi_address};

  bank_cmd_arbiter #(.NBANKS(NB), .ABITS(AB), .BABITS(BAB),
                     .TRRD(TRRD), .TRTW(TRTW), .TWTR(TWTR)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_a(cmd_payload_a),
    .cmd_payload_cas(cmd_payload_cas), .cmd_payload_ras(cmd_payload_ras),
    .cmd_payload_we(cmd_payload_we), .cmd_payload_is_cmd(cmd_payload_is_cmd),
    .cmd_payload_is_read(cmd_payload_is_read), .cmd_payload_is_write(cmd_payload_is_write),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_address(dfi_address), .dfi_bank(dfi_bank),
    .dfi_rddata_en(dfi_rddata_en), .dfi_wrdata_en(dfi_wrdata_en));

  always #5 sys_clk = ~sys_clk;

  // Per-bank pending command (a bank machine holds it until accepted)
  bit            pv[NB];
  int            pt[NB];
  logic [AB-1:0] pa[NB];
  bit            drop[NB];
  int            rdy_cyc[NB];

  int n_vec = 0, n_err = 0;
  int cyc = 0, m_last = NB - 1, m_dir = 0, m_turn = 0, m_last_act = -1000;
  int act_hist[$];
  logic [22:0] e_dfi = DFI_NOP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // {is_cmd, is_read, is_write, ras, cas, we}
  function automatic logic [5:0] enc(input int t);
    case (t)
      T_ACT:   return 6'b100_100;
      T_PRE:   return 6'b100_101;
      T_RD:    return 6'b010_010;
      default: return 6'b001_011;
    endcase
  endfunction

  function automatic bit faw_ok();
`ifdef BANK_CMD_ARBITER_TFAW_EN
    int n = 0;
    foreach (act_hist[j]) if (cyc - act_hist[j] < TFAW) n++;
    return n < 4;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit elig(input int i);
    if (!(pv[i] && !drop[i])) return 1'b0;
    case (pt[i])
      T_ACT:   return (cyc - m_last_act >= TRRD) && faw_ok();
      T_RD:    return m_dir == 0 && m_turn == 0;
      T_WR:    return m_dir == 1 && m_turn == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic apply();
    logic [5:0] e;
    for (int i = 0; i < NB; i++) begin
      e = enc(pt[i]);
      cmd_valid[i]            = pv[i] && !drop[i];
      cmd_payload_a[i*AB +: AB] = pa[i];
      cmd_payload_is_cmd[i]   = e[5];
      cmd_payload_is_read[i]  = e[4];
      cmd_payload_is_write[i] = e[3];
      cmd_payload_ras[i]      = e[2];
      cmd_payload_cas[i]      = e[1];
      cmd_payload_we[i]       = e[0];
    end
  endtask

  // One clock cycle: drive, check ready and DFI, advance the model
  task automatic cycle();
    int g;
    int i;
    bit any_rd, any_wr;
    logic [NB-1:0] exp_rdy;
    logic [5:0] e;
    apply();
    #4;
    g = -1;
    if (!sys_rst)
      for (int k = 1; k <= NB; k++) begin
        i = (m_last + k) % NB;
        if (g < 0 && elig(i)) g = i;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    chk("dfi_out", 32'(dfi_vec), 32'(e_dfi));
    for (int b = 0; b < NB; b++) if (cmd_ready[b]) rdy_cyc[b] = cyc;
    e_dfi = DFI_NOP;
    if (!sys_rst) begin
      any_rd = 0;
      any_wr = 0;
      for (int b = 0; b < NB; b++) begin
        if (pv[b] && !drop[b] && pt[b] == T_RD) any_rd = 1;
        if (pv[b] && !drop[b] && pt[b] == T_WR) any_wr = 1;
      end
      if (m_turn > 0) begin
        m_turn--;
        if (m_turn == 0) m_dir = 1 - m_dir;
      end else if (m_dir == 0 && !any_rd && any_wr) m_turn = TRTW;
      else if (m_dir == 1 && !any_wr && any_rd) m_turn = TWTR;
      if (g >= 0) begin
        e = enc(pt[g]);
        e_dfi = {1'b0, ~e[2], ~e[1], ~e[0], e[4], e[3], BAB'(g), pa[g]};
        m_last = g;
        if (pt[g] == T_ACT) begin
          m_last_act = cyc;
          act_hist.push_back(cyc);
          if (act_hist.size() > 8) void'(act_hist.pop_front());
        end
        pv[g] = 0;
      end
    end
    cyc++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    m_last = NB - 1; m_dir = 0; m_turn = 0; m_last_act = -1000;
    act_hist.delete();
    e_dfi = DFI_NOP;
  endtask

  task automatic set_cmd(input int b, input int t);
    pv[b] = 1; pt[b] = t; pa[b] = AB'($urandom);
  endtask

  task automatic clear_all();
    for (int b = 0; b < NB; b++) begin pv[b] = 0; drop[b] = 0; rdy_cyc[b] = -1; end
  endtask

  initial begin
    sys_rst = 1'b1;
    clear_all();
    for (int b = 0; b < NB; b++) begin pt[b] = T_PRE; pa[b] = '0; end
    apply();
    #1;
    chk("reset_ready", 32'(cmd_ready), 32'(0));
    chk("reset_dfi", 32'(dfi_vec), 32'(DFI_NOP));
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    // Idle after reset: no grants, NOP on DFI
    repeat (10) cycle();

    // Continuous READs on all banks: strict rotation starting at bank 0
    for (int b = 0; b < NB; b++) set_cmd(b, T_RD);
    for (int n = 0; n < 9; n++) begin
      cycle();
      chk("rr_order", 32'(rdy_cyc[n % NB]), 32'(cyc - 1));
      for (int b = 0; b < NB; b++) if (!pv[b]) set_cmd(b, T_RD);
    end
    clear_all();
    repeat (2) cycle();

    // Two simultaneous ACTs spaced by tRRD
    set_cmd(2, T_ACT);
    set_cmd(5, T_ACT);
    repeat (5) cycle();
    chk("act_first_bank2", 32'(rdy_cyc[2] >= 0 && rdy_cyc[2] < rdy_cyc[5]), 32'(1));
    chk("trrd_gap", 32'(rdy_cyc[5] - rdy_cyc[2]), 32'(TRRD));
    clear_all();

    // READ then pending WRITE: read-to-write turnaround
    set_cmd(1, T_RD);
    set_cmd(3, T_WR);
    repeat (10) cycle();
    chk("rtw_gap", 32'(rdy_cyc[3] >= 0 && rdy_cyc[3] - rdy_cyc[1] >= TRTW + 1), 32'(1));
    clear_all();

    // WRITE then READ, with an ACT slipping in during write-to-read turnaround
    set_cmd(4, T_WR);
    set_cmd(6, T_RD);
    repeat (3) cycle();
    set_cmd(0, T_ACT);
    repeat (10) cycle();
    chk("wtr_gap", 32'(rdy_cyc[6] >= 0 && rdy_cyc[6] - rdy_cyc[4] >= TWTR + 1), 32'(1));
    chk("act_in_wtr", 32'(rdy_cyc[0] > rdy_cyc[4] && rdy_cyc[0] < rdy_cyc[6]), 32'(1));
    clear_all();

    // Random traffic with valid drops and a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NB; b++) begin
        if (!pv[b] && $urandom_range(0, 2) == 0) set_cmd(b, int'($urandom_range(0, 3)));
        drop[b] = ($urandom_range(0, 7) == 0);
      end
      if (n == 1500) begin
        apply();
        sys_rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(cmd_ready), 32'(0));
        chk("midrst_dfi", 32'(dfi_vec), 32'(DFI_NOP));
        model_reset();
        @(posedge sys_clk);
        #1;
        repeat (2) cycle();
        sys_rst = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
